// File: rtl/lmem_arbiter.sv
// Round-robin arbiter sharing the layer-memory port between the conv engine (A)
// and the max-pool engine (B); registered bus outputs, 2-cycle read return.
module lmem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [2:0]        a_sel,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [2:0]        b_sel,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic              cwr,
    output logic              crd,
    output logic [2:0]        csel,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [ADDR_W-1:0] caddr_rd,
    output logic [DATA_W-1:0] cdata_wr,
    input  logic [DATA_W-1:0] cdata_rd
);

    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

    logic              last_q;
    logic              cwr_q, crd_q;
    logic [2:0]        csel_q;
    logic [ADDR_W-1:0] caddr_wr_q, caddr_rd_q;
    logic [DATA_W-1:0] cdata_wr_q;
    logic              rd_tag_q;
    logic              a_rvalid_q, b_rvalid_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

    logic              any_gnt;
    logic              g_we;
    logic [2:0]        g_sel;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    // On a tie the port not granted most recently wins.
    always_comb begin
        a_gnt = ~reset & a_req & (~b_req | (last_q == LAST_B));
        b_gnt = ~reset & b_req & (~a_req | (last_q == LAST_A));
        any_gnt = a_gnt | b_gnt;
        g_we    = a_gnt ? a_we    : b_we;
        g_sel   = a_gnt ? a_sel   : b_sel;
        g_addr  = a_gnt ? a_addr  : b_addr;
        g_wdata = a_gnt ? a_wdata : b_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q     <= LAST_B;
            cwr_q      <= 1'b0;
            crd_q      <= 1'b0;
            csel_q     <= '0;
            caddr_wr_q <= '0;
            caddr_rd_q <= '0;
            cdata_wr_q <= '0;
            rd_tag_q   <= LAST_A;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            if (a_gnt) begin
                last_q <= LAST_A;
            end else if (b_gnt) begin
                last_q <= LAST_B;
            end

            cwr_q <= any_gnt & g_we;
            crd_q <= any_gnt & ~g_we;
            if (any_gnt) begin
                csel_q <= g_sel;
                if (g_we) begin
                    caddr_wr_q <= g_addr;
                    cdata_wr_q <= g_wdata;
                end else begin
                    caddr_rd_q <= g_addr;
                    rd_tag_q   <= b_gnt ? LAST_B : LAST_A;
                end
            end

            // Tag travels with the read so interleaved returns reach the right port.
            a_rvalid_q <= crd_q & (rd_tag_q == LAST_A);
            b_rvalid_q <= crd_q & (rd_tag_q == LAST_B);
            if (crd_q && rd_tag_q == LAST_A) begin
                a_rdata_q <= cdata_rd;
            end
            if (crd_q && rd_tag_q == LAST_B) begin
                b_rdata_q <= cdata_rd;
            end
        end
    end

    assign cwr      = cwr_q;
    assign crd      = crd_q;
    assign csel     = csel_q;
    assign caddr_wr = caddr_wr_q;
    assign caddr_rd = caddr_rd_q;
    assign cdata_wr = cdata_wr_q;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_lmem_arbiter.sv
// Directed bench for lmem_arbiter with a simple layer-memory model on the bus side.
module tb_lmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [2:0]  a_sel, b_sel;
    logic [11:0] a_addr, b_addr;
    logic [19:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [19:0] a_rdata, b_rdata;
    logic        cwr, crd;
    logic [2:0]  csel;
    logic [11:0] caddr_wr, caddr_rd;
    logic [19:0] cdata_wr, cdata_rd;

    logic [19:0] mem [0:4095];
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [19:0] pre_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (cwr) mem[caddr_wr] <= cdata_wr;
    end
    assign cdata_rd = crd ? mem[caddr_rd] : 20'h0;

    lmem_arbiter #(.ADDR_W(12), .DATA_W(20)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_sel(a_sel), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_sel(b_sel), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .cwr(cwr), .crd(crd), .csel(csel), .caddr_wr(caddr_wr), .caddr_rd(caddr_rd),
        .cdata_wr(cdata_wr), .cdata_rd(cdata_rd)
    );

    // Registered outputs are sampled 1 time unit after the edge; new inputs are
    // applied then, and grants are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_req = 1'b1; b_req = 1'b1;
        step();
        #1;
        checks++;
        if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt: got a=%b b=%b want 0 0", a_gnt, b_gnt);
        end
        checks++;
        if ({cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr} !== 49'h0) begin
            errors++;
            $display("FAIL reset_bus: cwr=%b crd=%b csel=%h aw=%h ar=%h dw=%h want all 0",
                     cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr);
        end
        checks++;
        if ({a_rvalid, b_rvalid, a_rdata, b_rdata} !== 42'h0) begin
            errors++;
            $display("FAIL reset_ret: av=%b bv=%b ad=%h bd=%h want all 0",
                     a_rvalid, b_rvalid, a_rdata, b_rdata);
        end
        a_req = 1'b0; b_req = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        a_req = 1'b1; a_we = 1'b1; a_sel = 3'b001; a_addr = 12'h041; a_wdata = 20'h0ABCD;
        #1;
        checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            errors++;
            $display("FAIL wr_gnt: got a=%b b=%b want 1 0", a_gnt, b_gnt);
        end
        step();
        a_req = 1'b0;
        checks++;
        if (cwr !== 1'b1 || crd !== 1'b0 || csel !== 3'b001 || caddr_wr !== 12'h041
            || cdata_wr !== 20'h0ABCD) begin
            errors++;
            $display("FAIL wr_bus: cwr=%b crd=%b csel=%b aw=%h dw=%h want 1 0 001 041 0abcd",
                     cwr, crd, csel, caddr_wr, cdata_wr);
        end
        // B read of the same address on the very next grant
        b_req = 1'b1; b_we = 1'b0; b_sel = 3'b010; b_addr = 12'h041; b_wdata = 20'h12345;
        #1;
        checks++;
        if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rd_gnt: got a=%b b=%b want 0 1", a_gnt, b_gnt);
        end
        step();
        b_req = 1'b0;
        checks++;
        if (crd !== 1'b1 || cwr !== 1'b0 || csel !== 3'b010 || caddr_rd !== 12'h041
            || caddr_wr !== 12'h041 || cdata_wr !== 20'h0ABCD) begin
            errors++;
            $display("FAIL rd_bus: crd=%b cwr=%b csel=%b ar=%h aw=%h dw=%h want 1 0 010 041 041 0abcd",
                     crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr);
        end
        step();
        checks++;
        if (b_rvalid !== 1'b1 || b_rdata !== 20'h0ABCD || a_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_ret: bv=%b bd=%h av=%b want 1 0abcd 0", b_rvalid, b_rdata, a_rvalid);
        end
        checks++;
        if (crd !== 1'b0 || cwr !== 1'b0 || csel !== 3'b010) begin
            errors++;
            $display("FAIL idle_bus: crd=%b cwr=%b csel=%b want 0 0 010", crd, cwr, csel);
        end
        step();
        checks++;
        if (b_rvalid !== 1'b0 || b_rdata !== 20'h0ABCD) begin
            errors++;
            $display("FAIL rd_hold: bv=%b bd=%h want 0 0abcd", b_rvalid, b_rdata);
        end
    endtask

    task automatic test_round_robin();
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_we = 1'b1; a_sel = 3'b100; a_addr = 12'h010; a_wdata = 20'h00111;
        b_we = 1'b0; b_sel = 3'b101; b_addr = 12'h041;
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) begin
                checks++;
                if (cwr !== (i % 2 == 1) || crd !== (i % 2 == 0)) begin
                    errors++;
                    $display("FAIL rr_bus[%0d]: cwr=%b crd=%b want %b %b",
                             i, cwr, crd, i % 2 == 1, i % 2 == 0);
                end
            end
            if (i < 6) begin
                a_req = 1'b1; b_req = 1'b1;
                #1;
                checks++;
                if (a_gnt !== (i % 2 == 0) || b_gnt !== (i % 2 == 1)) begin
                    errors++;
                    $display("FAIL rr_gnt[%0d]: a=%b b=%b want %b %b",
                             i, a_gnt, b_gnt, i % 2 == 0, i % 2 == 1);
                end
                step();
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_interleave();
        pre_we = 1'b1; pre_addr = 12'h000; pre_data = 20'h00011;
        step();
        pre_addr = 12'h001; pre_data = 20'h00022;
        step();
        pre_we = 1'b0;
        a_we = 1'b0; a_addr = 12'h000; a_sel = 3'b000;
        b_we = 1'b0; b_addr = 12'h001; b_sel = 3'b000;
        // Last grant was B, so A leads: grants A,B,A,B in cycles 0..3.
        for (int i = 0; i < 6; i++) begin
            if (i >= 2) begin
                checks++;
                if (i % 2 == 0) begin
                    if (a_rvalid !== 1'b1 || a_rdata !== 20'h00011 || b_rvalid !== 1'b0) begin
                        errors++;
                        $display("FAIL il_ret[%0d]: av=%b ad=%h bv=%b want 1 00011 0",
                                 i, a_rvalid, a_rdata, b_rvalid);
                    end
                end else begin
                    if (b_rvalid !== 1'b1 || b_rdata !== 20'h00022 || a_rvalid !== 1'b0) begin
                        errors++;
                        $display("FAIL il_ret[%0d]: bv=%b bd=%h av=%b want 1 00022 0",
                                 i, b_rvalid, b_rdata, a_rvalid);
                    end
                end
            end
            a_req = (i < 4); b_req = (i < 4);
            #1;
            if (i < 4) begin
                checks++;
                if (a_gnt !== (i % 2 == 0) || b_gnt !== (i % 2 == 1)) begin
                    errors++;
                    $display("FAIL il_gnt[%0d]: a=%b b=%b want %b %b",
                             i, a_gnt, b_gnt, i % 2 == 0, i % 2 == 1);
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        b_we = 1'b1; b_sel = 3'b011;
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                checks++;
                if (cwr !== 1'b1 || crd !== 1'b0 || csel !== 3'b011
                    || caddr_wr !== 12'(i - 1) || cdata_wr !== 20'(20'h00100 + i - 1)) begin
                    errors++;
                    $display("FAIL b2b_bus[%0d]: cwr=%b crd=%b csel=%b aw=%h dw=%h want 1 0 011 %h %h",
                             i, cwr, crd, csel, caddr_wr, cdata_wr, i - 1, 20'h00100 + i - 1);
                end
            end
            if (i < 4) begin
                b_req = 1'b1; b_addr = 12'(i); b_wdata = 20'(20'h00100 + i);
                #1;
                checks++;
                if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_gnt[%0d]: a=%b b=%b want 0 1", i, a_gnt, b_gnt);
                end
                step();
            end
        end
        b_req = 1'b0;
        step();
        checks++;
        if (cwr !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: cwr=%b want 0", cwr);
        end
    endtask

    task automatic test_reset_mid_read();
        a_req = 1'b1; a_we = 1'b0; a_addr = 12'h000; a_sel = 3'b110;
        step();
        a_req = 1'b0;
        checks++;
        if (crd !== 1'b1) begin
            errors++;
            $display("FAIL mid_crd: crd=%b want 1", crd);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr} !== 49'h0
            || {a_rvalid, b_rvalid, a_rdata, b_rdata} !== 42'h0) begin
            errors++;
            $display("FAIL mid_reset: cwr=%b crd=%b csel=%h aw=%h ar=%h dw=%h av=%b bv=%b ad=%h bd=%h want all 0",
                     cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr,
                     a_rvalid, b_rvalid, a_rdata, b_rdata);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL mid_norv[%0d]: av=%b bv=%b want 0 0", i, a_rvalid, b_rvalid);
            end
        end
        a_req = 1'b1; b_req = 1'b1;
        #1;
        checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            errors++;
            $display("FAIL mid_tie: a=%b b=%b want 1 0", a_gnt, b_gnt);
        end
        a_req = 1'b0; b_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_sel = 3'b0; a_addr = 12'h0; a_wdata = 20'h0;
        b_req = 1'b0; b_we = 1'b0; b_sel = 3'b0; b_addr = 12'h0; b_wdata = 20'h0;
        pre_we = 1'b0; pre_addr = 12'h0; pre_data = 20'h0;
        step();
        test_reset();
        test_write_read();
        test_round_robin();
        test_interleave();
        test_back_to_back();
        test_reset_mid_read();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lmem_arbiter.md
# lmem_arbiter

Round-robin arbiter sharing the single layer-memory port (csel/cwr/crd/caddr_wr/caddr_rd/cdata_wr/cdata_rd) between two requesters: port A, the convolution engine writing layer-0 results, and port B, the max-pool engine reading layer 0 and writing layer 1. It accepts at most one transaction per cycle, drives registered memory-bus outputs and returns read data to the issuing port with fixed latency. It sits between the compute engines and the testbench-side layer memory.

## Interface
- ADDR_W, 12, layer-memory address width
- DATA_W, 20, layer-memory data width (signed two's complement, passed through unmodified)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- a_req  in  1  port A transaction request
- a_we  in  1  1 = write, 0 = read (valid with a_req)
- a_sel  in  3  memory select, copied to csel
- a_addr  in  ADDR_W  address
- a_wdata  in  DATA_W  write data
- a_gnt  out  1  combinational; request accepted this cycle
- a_rvalid  out  1  read data valid, one-cycle pulse
- a_rdata  out  DATA_W  read data
- b_req, b_we, b_sel, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as port A for port B
- cwr  out  1  memory write strobe
- crd  out  1  memory read strobe
- csel  out  3  memory select
- caddr_wr  out  ADDR_W  write address
- caddr_rd  out  ADDR_W  read address
- cdata_wr  out  DATA_W  write data
- cdata_rd  in  DATA_W  read data, valid combinationally for caddr_rd while crd=1

## Operation
- Arbitration state: pointer LAST ∈ {A, B} = port granted most recently; reset value B (so A wins first tie).
- Grant rules, per cycle: only a_req → a_gnt; only b_req → b_gnt; both → port ≠ LAST. Never both grants. LAST updates only on a grant.
- Requester holds req and all qualifiers stable until gnt; deasserting req before gnt is legal (request withdrawn, no transaction).
- Granted write: next cycle cwr=1, crd=0, csel=sel, caddr_wr=addr, cdata_wr=wdata; caddr_rd holds previous value.
- Granted read: next cycle crd=1, cwr=0, csel=sel, caddr_rd=addr; caddr_wr and cdata_wr hold.
- No grant: cwr=0, crd=0; csel, addresses, cdata_wr hold last values.
- cwr and crd never both 1.
- Read return: cdata_rd captured at end of the crd cycle; issuing port's rvalid=1 and rdata=captured value the following cycle. Tag (A/B) pipelined with the read so returns route correctly even when ports interleave.
- rdata holds last returned value when rvalid=0.
- Back-to-back: one transaction per cycle sustained; single requester holding req is granted every cycle.

## Timing
- Reset values: a_gnt=b_gnt=0 (during reset, grants forced 0), a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, cwr=0, crd=0, csel=0, caddr_wr=0, caddr_rd=0, cdata_wr=0, LAST=B.
- Cycle N: req high, gnt high (combinational). Edge N→N+1: bus registers load.
- Write: cwr=1 in cycle N+1; memory commits at edge N+1→N+2.
- Read: crd=1 in cycle N+1; rvalid=1 in cycle N+2. Latency req-accept to data = 2 cycles.
- Reset asserted mid-transaction: all in-flight reads discarded, no rvalid after reset, bus strobes 0 from the first cycle after the reset edge.
- Write then read of same address on consecutive grants returns the new data (memory commits write before read cycle).

## Test plan
- A writes 20'h0ABCD to addr 12'h041 sel 3'b001 → cycle N a_gnt=1; N+1 cwr=1, csel=001, caddr_wr=041, cdata_wr=0ABCD, crd=0.
- B reads addr 12'h041 after that write → b_gnt cycle M, crd=1/caddr_rd=041 at M+1, b_rvalid=1, b_rdata=0ABCD at M+2, a_rvalid stays 0.
- a_req and b_req both held high 6 cycles after reset → grants A,B,A,B,A,B; cwr/crd pattern matches each port's we.
- A reads 12'h000 and B reads 12'h001 alternately, memory preloaded 20'h00011/20'h00022 → a_rvalid carries 00011, b_rvalid carries 00022, never swapped.
- Only B requests 4 consecutive writes sel 3'b011 addr 0..3 → b_gnt=1 every cycle, cwr=1 four consecutive cycles, caddr_wr 0,1,2,3.
- Reset asserted the cycle crd=1 → no rvalid on either port afterwards; all outputs at reset values; next simultaneous request grants A.
